// File: rtl/cpu_pkg.sv
// Shared definitions for the simple_cpu front end: instruction class
// encodings, per-class hold lengths and the fetch-stage state type.
package cpu_pkg;

    localparam logic [1:0] CLS_HALT  = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    // Cycles the CU spends on each class (DECODE-EXECUTE-WRITE_BACK and
    // DECODE-EXECUTE-MEM_ACCESS-WRITE_BACK).
    localparam int LEN_STD = 3;
    localparam int LEN_MEM = 4;

    // The CU needs one extra cycle to leave its RESET state on the first word.
    localparam int CU_RESET_EXTRA = 1;

    // Hold counter width; largest value loaded is LEN_MEM + CU_RESET_EXTRA = 5.
    localparam int CNT_BITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Number of cycles a word of the given class stays on the CU input.
    // A halt word has no hold length; it freezes the stage instead.
    function automatic logic [CNT_BITS-1:0] hold_len(input logic [1:0] cls);
        logic [CNT_BITS-1:0] len;
        case (cls)
            CLS_STD:            len = CNT_BITS'(LEN_STD);
            CLS_LOAD, CLS_STORE: len = CNT_BITS'(LEN_MEM);
            default:            len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Writable program memory: synchronous write port, asynchronous read port.
module instr_rom #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [PC_BITS-1:0]     waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [PC_BITS-1:0]     raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

    // Program load: write one word per enabled edge.
    // NOTE: the array has no reset on purpose -- the program must survive a
    // reset of the fetch stage, and a reset port would also stop the array
    // mapping onto RAM/LUT-RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the simple_cpu CU. Presents each program
// word for as many cycles as the CU needs for its class, then advances.
// Stops on a class-00 word or at the end of program memory.
// Build option INSTR_FETCH_LOOP_EN: wrap from the last word back to address 0
// instead of halting at the end of memory.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted
);

    localparam logic [PC_BITS-1:0] PC_LAST = {PC_BITS{1'b1}};

    fetch_state_t           state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [PC_BITS-1:0]     pc_d;
    logic [INSTR_WIDTH-1:0] instr_d;

    logic [PC_BITS-1:0]     rom_addr;
    logic [INSTR_WIDTH-1:0] rom_rdata;
    logic [1:0]             rom_cls;
    logic                   rom_we;

    assign rom_cls = rom_rdata[INSTR_WIDTH-1 -: 2];

    // The program may only change while nothing is being executed.
    assign rom_we = prog_we && ((state_q == IDLE) || (state_q == HALT));

    instr_rom #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_BITS     (PC_BITS)
    ) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rom_addr),
        .rdata (rom_rdata)
    );

    // Next-state, next-PC, next-word and hold-counter logic.
    // NOTE: every target gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc;
        instr_d  = instruction;
        rom_addr = pc + 1'b1;   // wraps to 0 after the last word

        case (state_q)
            IDLE: begin
                rom_addr = '0;
                if (start) begin
                    // Reads the pre-write contents if a write lands on this edge.
                    instr_d = rom_rdata;
                    pc_d    = '0;
                    if (rom_cls == CLS_HALT) begin
                        cnt_d   = '0;
                        state_d = HALT;
                    end else begin
                        cnt_d   = hold_len(rom_cls) + CNT_BITS'(CU_RESET_EXTRA);
                        state_d = FIRST;
                    end
                end
            end

            FIRST, RUN: begin
                if (cnt_q > CNT_BITS'(1)) begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end else begin
`ifdef INSTR_FETCH_LOOP_EN
                    pc_d    = pc + 1'b1;
                    instr_d = rom_rdata;
                    cnt_d   = hold_len(rom_cls);
                    state_d = (rom_cls == CLS_HALT) ? HALT : RUN;
`else
                    if (pc == PC_LAST) begin
                        // Ran off the end of memory: drop the word, keep the PC.
                        instr_d = '0;
                        cnt_d   = '0;
                        state_d = HALT;
                    end else begin
                        pc_d    = pc + 1'b1;
                        instr_d = rom_rdata;
                        cnt_d   = hold_len(rom_cls);
                        state_d = (rom_cls == CLS_HALT) ? HALT : RUN;
                    end
`endif
                end
            end

            HALT: begin
                // Frozen until reset.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, word and counter registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc          <= '0;
            instruction <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc          <= pc_d;
            instruction <= instr_d;
        end
    end

    assign busy   = (state_q == FIRST) || (state_q == RUN);
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a vector table for the basic program
// timing, directed sequences for write protection, reset mid-run and end of
// memory, and random programs checked against a per-word hold-length model.
module tb_instr_fetch;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic [19:0] instruction;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;

    int checks = 0;
    int failures = 0;

    logic [19:0] prog [DEPTH];

    instr_fetch #(
        .INSTR_WIDTH (20),
        .PC_BITS     (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_v;
        logic        start_v;
        logic        we_v;
        logic [4:0]  addr;
        logic [19:0] data;
        logic [19:0] e_instr;
        logic [4:0]  e_pc;
        logic        e_busy;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pack(input logic [19:0] i, input logic [4:0] p,
                                         input logic b, input logic h);
        return {5'd0, i, p, b, h};
    endfunction

    function automatic logic [31:0] obs();
        return pack(instruction, pc, busy, halted);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h ({instr,pc,busy,halted})", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = 5'(i);
            prog_data = prog[i];
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic v(input logic r, input logic s, input logic we, input logic [4:0] a,
                     input logic [19:0] d, input logic [19:0] ei, input logic [4:0] ep,
                     input logic eb, input logic eh, input int n);
        vec_t t;
        t.rst_v = r; t.start_v = s; t.we_v = we; t.addr = a; t.data = d;
        t.e_instr = ei; t.e_pc = ep; t.e_busy = eb; t.e_halted = eh;
        for (int i = 0; i < n; i++) begin
            vecs.push_back(t);
            t.start_v = 1'b0;   // start is a one-cycle pulse in repeated rows
        end
    endtask

    function automatic int hold_of(input logic [1:0] cls);
        return (cls == 2'b01) ? 3 : 4;
    endfunction

    // Reference: walk the program word by word, emitting one expected output
    // record per cycle after the start edge.
    task automatic run_model(input string name, input int limit, input bit noise);
        logic [31:0] exp_q[$];
        int  k = 0;
        bit  first = 1'b1;
        bit  done = 1'b0;
        while (!done && exp_q.size() < limit) begin
            logic [19:0] w;
            w = prog[k];
            if (w[19:18] == 2'b00) begin
                while (exp_q.size() < limit) exp_q.push_back(pack(w, 5'(k), 1'b0, 1'b1));
                done = 1'b1;
            end else begin
                int hold;
                hold  = hold_of(w[19:18]) + (first ? 1 : 0);
                first = 1'b0;
                for (int c = 0; c < hold; c++) exp_q.push_back(pack(w, 5'(k), 1'b1, 1'b0));
                if (k == DEPTH - 1) begin
`ifdef INSTR_FETCH_LOOP_EN
                    k = 0;
`else
                    while (exp_q.size() < limit) exp_q.push_back(pack(20'h0, 5'd31, 1'b0, 1'b1));
                    done = 1'b1;
`endif
                end else begin
                    k++;
                end
            end
        end
        while (exp_q.size() > limit) void'(exp_q.pop_back());

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), obs(), exp_q[i]);
            if (noise) begin
                // Writes and start pulses while running must be ignored;
                // once halted, writes land but outputs stay frozen.
                start     = 1'($urandom_range(0, 1));
                prog_we   = 1'($urandom_range(0, 1));
                prog_addr = 5'($urandom_range(0, DEPTH - 1));
                prog_data = 20'($urandom);
            end
            step();
        end
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    initial begin
        // ---------------- table-driven: 3-word program timing ----------------
        v(0, 0, 0, 0, 20'h0,     20'h0,     0, 0, 0, 1);  // reset
        v(1, 0, 1, 0, 20'h41230, 20'h0,     0, 0, 0, 1);
        v(1, 0, 1, 1, 20'h80041, 20'h0,     0, 0, 0, 1);
        v(1, 0, 1, 2, 20'h00000, 20'h0,     0, 0, 0, 1);
        v(1, 1, 0, 0, 20'h0,     20'h41230, 0, 1, 0, 4);  // std + CU reset cycle
        v(1, 0, 0, 0, 20'h0,     20'h80041, 1, 1, 0, 4);  // load
        v(1, 0, 0, 0, 20'h0,     20'h00000, 2, 0, 1, 1);  // halt word
        v(1, 1, 0, 0, 20'h0,     20'h00000, 2, 0, 1, 1);  // start ignored in HALT
        v(1, 0, 1, 2, 20'h40001, 20'h00000, 2, 0, 1, 1);  // write in HALT, frozen
        v(0, 0, 0, 0, 20'h0,     20'h0,     0, 0, 0, 1);  // back to IDLE
        v(1, 1, 1, 0, 20'hC0050, 20'h41230, 0, 1, 0, 4);  // start sees pre-write mem[0]
        v(1, 0, 0, 0, 20'h0,     20'h80041, 1, 1, 0, 4);
        v(1, 0, 0, 0, 20'h0,     20'h40001, 2, 1, 0, 2);  // written in HALT
        v(0, 0, 0, 0, 20'h0,     20'h0,     0, 0, 0, 1);  // reset mid-hold
        v(1, 1, 0, 0, 20'h0,     20'hC0050, 0, 1, 0, 5);  // store: 4 + 1 cycles
        v(1, 0, 0, 0, 20'h0,     20'h80041, 1, 1, 0, 1);
        v(0, 0, 0, 0, 20'h0,     20'h0,     0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst_v;
            start     = vecs[i].start_v;
            prog_we   = vecs[i].we_v;
            prog_addr = vecs[i].addr;
            prog_data = vecs[i].data;
            step();
            check($sformatf("vec[%0d]", i), obs(),
                  pack(vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_halted));
        end
        rst = 1'b1; start = 1'b0; prog_we = 1'b0;

        // ---------------- write protection while running ----------------
        for (int i = 0; i < DEPTH; i++) prog[i] = 20'h0;
        prog[0] = 20'h41230; prog[1] = 20'h80041; prog[2] = 20'h00000;
        do_reset();
        load_prog();
        start = 1'b1;
        step();
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'hFFFFF;
        step();
        prog_we = 1'b0;
        check("wp_hold_pc0", obs(), pack(20'h41230, 0, 1, 0));
        step(); step(); step();
        check("wp_word1_intact", obs(), pack(20'h80041, 1, 1, 0));
        prog_we = 1'b1; prog_addr = 5'd2; prog_data = 20'hFFFFF;
        step();
        prog_we = 1'b0;
        step(); step(); step();
        check("wp_word2_intact", obs(), pack(20'h00000, 2, 0, 1));
        do_reset();
        run_model("wp_rerun", 12, 1'b0);

        // ---------------- reset mid-run at pc=1, then re-run ----------------
        for (int i = 0; i < DEPTH; i++)
            prog[i] = {(i < 4) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3)), 18'($urandom)};
        do_reset();
        load_prog();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && pc !== 5'd1; c++) step();
        check("rst_wait_pc1", {27'd0, pc}, 32'd1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst_mid_run", obs(), pack(20'h0, 0, 0, 0));
        run_model("rst_rerun", 40, 1'b0);

        // ---------------- end of memory: all class 01 ----------------
        for (int i = 0; i < DEPTH; i++) prog[i] = {2'b01, 18'($urandom)};
        do_reset();
        load_prog();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int idx = 0; idx <= 100; idx++) begin
            if (idx == 0 || idx == 3) check($sformatf("eom[%0d]", idx), obs(), pack(prog[0], 0, 1, 0));
            if (idx == 4)  check("eom[4]", obs(), pack(prog[1], 1, 1, 0));
            if (idx == 96) check("eom[96]", obs(), pack(prog[31], 31, 1, 0));
`ifdef INSTR_FETCH_LOOP_EN
            if (idx == 97 || idx == 99) check($sformatf("loop[%0d]", idx), obs(), pack(prog[0], 0, 1, 0));
            if (idx == 100) check("loop[100]", obs(), pack(prog[1], 1, 1, 0));
`else
            if (idx == 97 || idx == 100) check($sformatf("eom_halt[%0d]", idx), obs(), pack(20'h0, 31, 0, 1));
`endif
            step();
        end

        // ---------------- random programs against the model ----------------
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < DEPTH; i++)
                prog[i] = {($urandom_range(0, 11) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                           18'($urandom)};
            do_reset();
            load_prog();
            run_model($sformatf("rand%0d", t), 160, 1'(t % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the CU in simple_cpu and drives its 20-bit `instruction` input.
- Holds a small writable program memory and a program counter (PC).
- Presents each instruction to the CU for exactly the number of cycles the CU needs for that instruction class, then advances to the next word.
- Stops on a halt word (class 00) or at the end of program memory.

Parameters:
- INSTR_WIDTH, 20, instruction word width; class field is bits [19:18].
- PC_BITS, 5, PC width; program memory depth is 2**PC_BITS words.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-low reset.
- start, input, 1, begin execution from address 0; honoured only in IDLE.
- prog_we, input, 1, program memory write enable; honoured only in IDLE or HALT.
- prog_addr, input, PC_BITS, program memory write address.
- prog_data, input, INSTR_WIDTH, program memory write data.
- instruction, output, INSTR_WIDTH, registered instruction driven to the CU `instr` input.
- pc, output, PC_BITS, address of the word currently on `instruction`.
- busy, output, 1, high in FIRST and RUN.
- halted, output, 1, high in HALT.

Behaviour:
- Reset (rst=0 at an edge):
  - Outputs: state=IDLE, instruction=0, pc=0, busy=0, halted=0, hold counter=0.
  - Program memory contents are retained, not cleared.
  - Reset mid-run aborts immediately with the same values.
- Read timing: program memory read is asynchronous (combinational from address). `instruction` is registered, so a newly loaded word appears the cycle after the load edge.
- Hold length per class, LEN(class):
  - 01 (std_op): 3 cycles.
  - 10 (loadR) / 11 (storeR): 4 cycles.
  - These match the CU paths DECODE-EXECUTE-WRITE_BACK and DECODE-EXECUTE-MEM_ACCESS-WRITE_BACK.
- State machine:
  - IDLE:
    - prog_we=1 writes prog_data to mem[prog_addr].
    - start=1 loads mem[0] into `instruction` and sets pc=0.
    - If mem[0] class is 00, go to HALT.
    - Otherwise set hold counter = LEN+1 (extra cycle for the CU leaving its RESET state) and go to FIRST.
  - FIRST / RUN, each cycle:
    - If counter > 1: decrement it.
    - If counter == 1: advance. pc<=pc+1, instruction<=mem[pc+1], counter<=LEN(new class), state=RUN.
    - If the newly loaded word has class 00: state=HALT, `instruction` holds that word, pc holds its address.
  - End of memory: advancing when pc == 2**PC_BITS-1 sets state=HALT, instruction<=0, pc unchanged.
  - HALT: outputs frozen; prog_we honoured; start ignored. Only rst returns to IDLE.
- Writes in FIRST/RUN: prog_we is ignored and memory is unchanged.
- Simultaneous start and prog_we in IDLE: the write completes at the same edge, but start reads the pre-write memory contents.
- Counter width: 3 bits (maximum value 5); it never underflows.

Optional Feature:
- Macro: INSTR_FETCH_LOOP_EN.
- Defined: advancing from pc == 2**PC_BITS-1 wraps to pc=0 and loads mem[0] with counter=LEN (no extra cycle). Execution continues until a class-00 word or reset.
- Undefined: end of memory enters HALT as described above.

Decomposition:
- Shared package cpu_pkg:
  - Class encodings CLS_HALT=2'b00, CLS_STD=2'b01, CLS_LOAD=2'b10, CLS_STORE=2'b11.
  - Hold lengths LEN_STD=3, LEN_MEM=4.
  - CU_RESET_EXTRA=1.
  - Fetch state enum {IDLE, FIRST, RUN, HALT}.
- One sub-module, instr_rom: 2**PC_BITS x INSTR_WIDTH array with a synchronous write port and an asynchronous read port.
- instr_fetch contains the FSM, PC and hold counter.

Test Plan:
- Timing of a 3-word program:
  - Stimulus: load mem[0]=20'h4_1230 (std), mem[1]=20'h8_0041 (load), mem[2]=20'h0_0000; pulse start.
  - Response: instruction=20'h41230 for 4 cycles (3+1), then 20'h80041 for 4 cycles, then 0 with halted=1 and pc=2.
- Store class:
  - Stimulus: mem[0]=20'hC_0050 followed by a halt word.
  - Response: word held 5 cycles, then HALT.
- End of memory (macro undefined):
  - Stimulus: fill all 32 words with class 01.
  - Response: after 32 instructions (first held 4 cycles, rest 3), instruction=0, pc=31, halted=1.
- Loop (INSTR_FETCH_LOOP_EN defined), same program as the end-of-memory test:
  - Response: after word 31, pc=0 and instruction=mem[0] held 3 cycles; busy stays 1.
- Write protection during run:
  - Stimulus: prog_we=1, prog_addr=1, prog_data=20'hFFFFF while in RUN at pc=0.
  - Response: mem[1] unchanged; the original word is presented next.
- Reset mid-run:
  - Stimulus: rst=0 for one edge at pc=1 mid-hold.
  - Response: next cycle instruction=0, pc=0, busy=0; memory retained, so a new start re-executes the same program.
